// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared CPU datapath widths and architectural register names
package cpu_pkg;

   // Register file geometry
   localparam int REG_ADDR_W = 5;
   localparam int DATA_W     = 32;
   localparam int NUM_REGS   = 2 ** REG_ADDR_W;

   typedef logic [REG_ADDR_W-1:0] reg_addr_t;
   typedef logic [DATA_W-1:0]     reg_data_t;

   // r0 is architecturally hardwired to zero
   localparam reg_addr_t REG_ZERO = 5'd0;

   // Named registers used by decode for implicit operands
   localparam reg_addr_t REG_AT = 5'd1;
   localparam reg_addr_t REG_V0 = 5'd2;
   localparam reg_addr_t REG_GP = 5'd28;
   localparam reg_addr_t REG_SP = 5'd29;
   localparam reg_addr_t REG_FP = 5'd30;
   localparam reg_addr_t REG_RA = 5'd31;

endpackage

// File: rtl/register_file.sv
// rtl/register_file.sv - 2-read/1-write register file with hardwired r0 and optional write forwarding
module register_file
   import cpu_pkg::*;
#(
   parameter int DATA_WIDTH   = DATA_W,
   parameter int ADDR_WIDTH   = REG_ADDR_W,
   parameter bit WRITE_BYPASS = 1'b1
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] rs,
   input  logic [ADDR_WIDTH-1:0] rt,
   input  logic [ADDR_WIDTH-1:0] rd,
   input  logic [DATA_WIDTH-1:0] input_data,
   output logic [DATA_WIDTH-1:0] output_data_A,
   output logic [DATA_WIDTH-1:0] output_data_B
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] regs [DEPTH];
   logic                  write_hit;

   // A write only takes effect outside reset and never to r0; the same
   // qualifier gates forwarding so a lost write is never seen on a read port.
   assign write_hit = reset_n && we && (rd != '0);

   // Storage: reset clears every entry and wins over a coincident write
   always_ff @(posedge clock) begin
      if (!reset_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs[i] <= '0;
         end
      end else if (write_hit) begin
         regs[rd] <= input_data;
      end
   end

   // Shared read-port logic: r0 masks to zero, then forwarding, then the array
   function automatic logic [DATA_WIDTH-1:0] read_port(
      input logic [ADDR_WIDTH-1:0] addr,
      input logic                  hit,
      input logic [ADDR_WIDTH-1:0] waddr,
      input logic [DATA_WIDTH-1:0] wdata,
      input logic [DATA_WIDTH-1:0] stored
   );
      if (addr == '0) begin
         return '0;
      end
      if (WRITE_BYPASS && hit && (addr == waddr)) begin
         return wdata;
      end
      return stored;
   endfunction

   // Read port A (rs)
   always_comb begin
      output_data_A = read_port(rs, write_hit, rd, input_data, regs[rs]);
   end

   // Read port B (rt)
   always_comb begin
      output_data_B = read_port(rt, write_hit, rd, input_data, regs[rt]);
   end

endmodule

// File: tb/tb_register_file.sv
// tb/tb_register_file.sv - directed vector bench for register_file, forwarding and non-forwarding builds
module tb_register_file;

   logic        clock;
   logic        reset_n;
   logic        we;
   logic [4:0]  rs;
   logic [4:0]  rt;
   logic [4:0]  rd;
   logic [31:0] input_data;
   logic [31:0] a_byp, b_byp;
   logic [31:0] a_nob, b_nob;

   int n_checks;
   int n_fail;

   register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .WRITE_BYPASS(1'b1)) dut_byp (
      .clock(clock), .reset_n(reset_n), .we(we), .rs(rs), .rt(rt), .rd(rd),
      .input_data(input_data), .output_data_A(a_byp), .output_data_B(b_byp)
   );

   register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .WRITE_BYPASS(1'b0)) dut_nob (
      .clock(clock), .reset_n(reset_n), .we(we), .rs(rs), .rt(rt), .rd(rd),
      .input_data(input_data), .output_data_A(a_nob), .output_data_B(b_nob)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   typedef struct {
      logic        rstn;
      logic        wen;
      logic [4:0]  wa;
      logic [4:0]  ra;
      logic [4:0]  rb;
      logic [31:0] wd;
      logic [31:0] exp_a;
      logic [31:0] exp_b;
      logic [31:0] exp_a_nob;
      logic [31:0] exp_b_nob;
   } vec_t;

   vec_t vecs [17];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check4(input string tag, input logic [31:0] ea, input logic [31:0] eb,
                         input logic [31:0] ea0, input logic [31:0] eb0);
      check({tag, " byp.A"}, a_byp, ea);
      check({tag, " byp.B"}, b_byp, eb);
      check({tag, " nob.A"}, a_nob, ea0);
      check({tag, " nob.B"}, b_nob, eb0);
   endtask

   initial begin
      logic [31:0] ei, ej;
      n_checks = 0;
      n_fail   = 0;

      //            rstn  we    rd     rs     rt     data           A              B              A(nob)         B(nob)
      vecs[0]  = '{1'b1, 1'b0, 5'd0,  5'd5,  5'd31, 32'h0,         32'h0,         32'h0,         32'h0,         32'h0};
      vecs[1]  = '{1'b1, 1'b1, 5'd0,  5'd0,  5'd0,  32'hFFFFFFFF,  32'h0,         32'h0,         32'h0,         32'h0};
      vecs[2]  = '{1'b1, 1'b0, 5'd0,  5'd0,  5'd1,  32'h0,         32'h0,         32'h0,         32'h0,         32'h0};
      vecs[3]  = '{1'b1, 1'b1, 5'd1,  5'd1,  5'd2,  32'hAAAAAAAA,  32'hAAAAAAAA,  32'h0,         32'h0,         32'h0};
      vecs[4]  = '{1'b1, 1'b0, 5'd0,  5'd1,  5'd2,  32'h0,         32'hAAAAAAAA,  32'h0,         32'hAAAAAAAA,  32'h0};
      vecs[5]  = '{1'b1, 1'b1, 5'd2,  5'd1,  5'd2,  32'h55555555,  32'hAAAAAAAA,  32'h55555555,  32'hAAAAAAAA,  32'h0};
      vecs[6]  = '{1'b1, 1'b0, 5'd0,  5'd1,  5'd2,  32'h0,         32'hAAAAAAAA,  32'h55555555,  32'hAAAAAAAA,  32'h55555555};
      vecs[7]  = '{1'b1, 1'b1, 5'd3,  5'd3,  5'd3,  32'h12345678,  32'h12345678,  32'h12345678,  32'h0,         32'h0};
      vecs[8]  = '{1'b1, 1'b0, 5'd0,  5'd3,  5'd0,  32'h0,         32'h12345678,  32'h0,         32'h12345678,  32'h0};
      vecs[9]  = '{1'b0, 1'b1, 5'd4,  5'd4,  5'd1,  32'hDEADBEEF,  32'h0,         32'hAAAAAAAA,  32'h0,         32'hAAAAAAAA};
      vecs[10] = '{1'b1, 1'b0, 5'd0,  5'd4,  5'd1,  32'h0,         32'h0,         32'h0,         32'h0,         32'h0};
      vecs[11] = '{1'b1, 1'b0, 5'd0,  5'd2,  5'd3,  32'h0,         32'h0,         32'h0,         32'h0,         32'h0};
      vecs[12] = '{1'b1, 1'b1, 5'd31, 5'd31, 5'd30, 32'hCAFEF00D,  32'hCAFEF00D,  32'h0,         32'h0,         32'h0};
      vecs[13] = '{1'b1, 1'b1, 5'd30, 5'd31, 5'd30, 32'h0BADC0DE,  32'hCAFEF00D,  32'h0BADC0DE,  32'hCAFEF00D,  32'h0};
      vecs[14] = '{1'b1, 1'b0, 5'd0,  5'd30, 5'd31, 32'h0,         32'h0BADC0DE,  32'hCAFEF00D,  32'h0BADC0DE,  32'hCAFEF00D};
      vecs[15] = '{1'b1, 1'b1, 5'd30, 5'd30, 5'd30, 32'h11111111,  32'h11111111,  32'h11111111,  32'h0BADC0DE,  32'h0BADC0DE};
      vecs[16] = '{1'b1, 1'b0, 5'd0,  5'd30, 5'd31, 32'h0,         32'h11111111,  32'hCAFEF00D,  32'h11111111,  32'hCAFEF00D};

      // Initial reset: held across the first rising edge
      reset_n    = 1'b0;
      we         = 1'b0;
      rs         = 5'd0;
      rt         = 5'd0;
      rd         = 5'd0;
      input_data = 32'h0;

      // Directed table: drive on the falling edge, check combinational outputs before the rising edge
      for (int v = 0; v < 17; v++) begin
         @(negedge clock);
         reset_n    = vecs[v].rstn;
         we         = vecs[v].wen;
         rd         = vecs[v].wa;
         rs         = vecs[v].ra;
         rt         = vecs[v].rb;
         input_data = vecs[v].wd;
         #1;
         check4($sformatf("vec%0d", v), vecs[v].exp_a, vecs[v].exp_b,
                vecs[v].exp_a_nob, vecs[v].exp_b_nob);
      end

      // Full sweep: reg[i] = i * 0x01010101, including a discarded write to r0
      for (int i = 0; i < 32; i++) begin
         @(negedge clock);
         reset_n    = 1'b1;
         we         = 1'b1;
         rd         = 5'(i);
         rs         = 5'd0;
         rt         = 5'd0;
         input_data = 32'(i) * 32'h01010101;
      end
      @(negedge clock);
      we = 1'b0;
      for (int i = 0; i < 32; i++) begin
         rs = 5'(i);
         rt = 5'(31 - i);
         #1;
         ei = (i == 0) ? 32'h0 : 32'(i) * 32'h01010101;
         ej = (i == 31) ? 32'h0 : 32'(31 - i) * 32'h01010101;
         check4($sformatf("sweep%0d", i), ei, ej, ei, ej);
      end

      // Reset after a full array: every register must read back zero
      @(negedge clock);
      reset_n = 1'b0;
      @(negedge clock);
      reset_n = 1'b1;
      for (int i = 0; i < 32; i++) begin
         rs = 5'(i);
         rt = 5'(31 - i);
         #1;
         check4($sformatf("postrst%0d", i), 32'h0, 32'h0, 32'h0, 32'h0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
